otter_fetch_stage: RTL and testbench

Instruction-fetch stage of the OTTER pipeline.
- Holds the PC register that consumes the 32-bit output of the PC-source 4-to-1 mux (next_pc) and drives pc/pc_plus4 back to that mux's inputs.
- Issues one-outstanding instruction-memory requests and captures the returned instruction into the IF/ID register.
- Supports hazard stall (pc_write), branch/jump redirect (flush) and downstream back-pressure (id_ready).

---
 rtl/otter_fetch_pkg.sv | 16 +
 rtl/otter_fetch_if_id_reg.sv | 67 ++++++
 rtl/otter_fetch_stage.sv | 134 +++++++++++++
 tb/tb_otter_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package otter_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/otter_fetch_if_id_reg.sv
// IF/ID holding register: valid flag, PC and instruction word (plus misalign flag).
// Latency: load/consume/clear take effect on the next rising edge.
// Backpressure: none internally; the owner gates load against slot availability.
// Ports: i_load captures i_pc/i_instr; i_consume vacates the slot unless a load
//        happens the same cycle; i_clear (flush) vacates it unconditionally.
// Optional: MISALIGN_CHK_EN adds i_misalign/o_misalign.
module if_id_reg (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_consume,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
`ifdef MISALIGN_CHK_EN
  input  logic        i_misalign,
  output logic        o_misalign,
`endif
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_instr <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MISALIGN_CHK_EN
  logic r_misalign;

  // Flag tracks the slot: it only survives while the same entry is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_misalign <= 1'b0;
    end else if (i_clear) begin
      r_misalign <= 1'b0;
    end else if (i_load) begin
      r_misalign <= i_misalign;
    end else if (i_consume) begin
      r_misalign <= 1'b0;
    end
  end

  assign o_misalign = r_misalign;
`endif

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: PC register, one-outstanding imem requests, IF/ID capture.
// Latency: IF/ID is written on the edge after imem_rvalid (request->ack->rvalid->capture).
// Backpressure: no request while pc_write=0 or IF/ID is full and not being consumed.
// Ports: i_next_pc/i_pc_write/i_flush from hazard & PC-source logic; o_imem_* / i_imem_*
//        to instruction memory; o_pc/o_pc_plus4 back to the PC-source mux; o_if_* to decode.
// Optional: MISALIGN_CHK_EN adds o_if_misalign and turns misaligned fetches into NOPs.
module otter_fetch_stage
  import otter_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_next_pc,
  input  logic        i_pc_write,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
`ifdef MISALIGN_CHK_EN
  output logic        o_if_misalign,
`endif
  input  logic        i_id_ready
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         w_req;
  logic         w_load;
  logic [31:0]  w_load_instr;
  logic         w_if_valid;
  logic         w_slot_free;
  logic         w_consume;
`ifdef MISALIGN_CHK_EN
  logic         w_load_mis;
`endif

  assign w_slot_free = !w_if_valid || i_id_ready;
  assign w_consume   = w_if_valid && i_id_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req        = 1'b0;
    w_load       = 1'b0;
    w_load_instr = i_imem_rdata;
`ifdef MISALIGN_CHK_EN
    w_load_mis   = 1'b0;
`endif
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
`ifdef MISALIGN_CHK_EN
        // Misaligned PC never reaches memory; a NOP stands in for it.
        if (!i_flush && (r_pc[1:0] != 2'b00) && i_pc_write && w_slot_free) begin
          w_load       = 1'b1;
          w_load_instr = NOP_INSTR;
          w_load_mis   = 1'b1;
          w_pc_nxt     = i_next_pc;
        end else begin
          w_req = i_pc_write && w_slot_free && !i_flush && (r_pc[1:0] == 2'b00);
          if (w_req && i_imem_ack) w_state_nxt = WAIT;
        end
`else
        w_req = i_pc_write && w_slot_free && !i_flush;
        if (w_req && i_imem_ack) w_state_nxt = WAIT;
`endif
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          w_state_nxt = FETCH;
          if (!i_flush) begin
            w_load = 1'b1;
            // A stalled capture keeps the PC so the same slot is refetched.
            if (i_pc_write) w_pc_nxt = i_next_pc;
          end
        end else if (i_flush) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (i_imem_rvalid) w_state_nxt = FETCH;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Redirect wins over any PC update chosen above.
    if (i_flush) w_pc_nxt = i_next_pc;
  end

  if_id_reg u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_consume  (w_consume),
    .i_clear    (i_flush),
    .i_pc       (r_pc),
    .i_instr    (w_load_instr),
`ifdef MISALIGN_CHK_EN
    .i_misalign (w_load_mis),
    .o_misalign (o_if_misalign),
`endif
    .o_valid    (w_if_valid),
    .o_pc       (o_if_pc),
    .o_instr    (o_if_instr)
  );

  assign o_imem_req = w_req;
`ifdef MISALIGN_CHK_EN
  assign o_imem_addr = r_pc;
`else
  assign o_imem_addr = {r_pc[31:2], 2'b00};
`endif
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc + 32'd4;
  assign o_if_valid = w_if_valid;

endmodule

// File: tb/tb_otter_fetch_stage.sv
module tb_otter_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1, flush = 1'b0, ack = 1'b1, rvalid = 1'b0, id_ready = 1'b1;
  logic [31:0] rdata = 32'h0;
  logic        follow = 1'b1;
  logic [31:0] np_fixed = 32'h0;
  logic [31:0] next_pc;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, pc, pc_plus4, if_pc, if_instr;
`ifdef MISALIGN_CHK_EN
  logic        if_misalign;
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  assign next_pc = follow ? pc_plus4 : np_fixed;

  otter_fetch_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_next_pc(next_pc), .i_pc_write(pc_write),
    .i_flush(flush), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(ack), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_if_valid(if_valid), .o_if_pc(if_pc),
    .o_if_instr(if_instr),
`ifdef MISALIGN_CHK_EN
    .o_if_misalign(if_misalign),
`endif
    .i_id_ready(id_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending request, whether its answer is to be
  // discarded, and the one-entry IF/ID slot.
  bit          m_started, m_pend, m_drop, m_vld, m_mis;
  logic [31:0] m_pc, m_ipc, m_instr;

  task automatic m_reset();
    m_started = 0; m_pend = 0; m_drop = 0; m_vld = 0; m_mis = 0;
    m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0;
  endtask

  function automatic bit m_misaligned();
    return MIS_EN && (m_pc[1:0] != 2'b00);
  endfunction

  function automatic bit m_can_issue();
    return m_started && !m_pend && pc_write && (!m_vld || id_ready) && !flush;
  endfunction

  function automatic bit m_req();
    return m_can_issue() && !m_misaligned();
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[11:0], 20'h0};
  endfunction

  // Responder + model advance, one clock per call.
  int          mem_lat = 1;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  task automatic step();
    bit s_fire, s_req, s_mis, s_cons, s_flush, s_rv, s_pw, cap;
    logic [31:0] s_np, s_rd, s_addr;
    @(negedge clk);
    s_fire = imem_req && ack;
    s_addr = imem_addr;
    s_req = m_req(); s_mis = m_can_issue() && m_misaligned();
    s_cons = m_vld && id_ready; s_flush = flush; s_rv = rvalid; s_pw = pc_write;
    s_np = next_pc; s_rd = rdata;
    @(posedge clk);
    if (rst_n) begin
      cap = 0;
      if (s_flush) begin
        m_pc = s_np; m_vld = 0; m_mis = 0;
        if (m_pend) begin
          if (s_rv) begin m_pend = 0; m_drop = 0; end
          else m_drop = 1;
        end
      end else begin
        if (s_req && ack) m_pend = 1;
        else if (s_mis) begin
          m_vld = 1; m_ipc = m_pc; m_instr = 32'h13; m_mis = 1; m_pc = s_np; cap = 1;
        end else if (m_pend && s_rv) begin
          if (!m_drop) begin
            m_vld = 1; m_ipc = m_pc; m_instr = s_rd; m_mis = 0; cap = 1;
            if (s_pw) m_pc = s_np;
          end
          m_pend = 0; m_drop = 0;
        end
        if (!cap && s_cons) begin m_vld = 0; m_mis = 0; end
      end
      m_started = 1;
    end
    #1;
    rvalid = 1'b0;
    if (s_fire) begin cnt = mem_lat; pend_addr = s_addr; end
    if (cnt == 1) begin rvalid = 1'b1; rdata = instr_of(pend_addr); cnt = 0; end
    else if (cnt > 0) cnt--;
  endtask

  task automatic wait_fire();
    int k = 0;
    while (!(imem_req && ack) && k < 20) begin step(); k++; end
    cmp("req_timeout", {31'b0, imem_req && ack}, 32'd1);
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cmp("m_imem_req", {31'b0, imem_req}, {31'b0, m_req()});
        cmp("m_imem_addr", imem_addr, MIS_EN ? m_pc : {m_pc[31:2], 2'b00});
        cmp("m_pc", pc, m_pc);
        cmp("m_pc_plus4", pc_plus4, m_pc + 32'd4);
        cmp("m_if_valid", {31'b0, if_valid}, {31'b0, m_vld});
        cmp("m_if_pc", if_pc, m_ipc);
        cmp("m_if_instr", if_instr, m_instr);
`ifdef MISALIGN_CHK_EN
        cmp("m_if_misalign", {31'b0, if_misalign}, {31'b0, m_mis});
`endif
      end
    end
  end

  initial begin
    m_reset();
    step(); step();
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_pc_plus4", pc_plus4, 32'h4);
    cmp("rst_req", {31'b0, imem_req}, 32'd0);
    cmp("rst_if_valid", {31'b0, if_valid}, 32'd0);
    cmp("rst_if_pc", if_pc, 32'h0);
    cmp("rst_if_instr", if_instr, 32'h0);
    rst_n = 1'b1;
    #1 cmp("idle_req", {31'b0, imem_req}, 32'd0);

    // Basic sequential fetch, 1-cycle memory.
    step();
    cmp("t1_req0", {31'b0, imem_req}, 32'd1);
    cmp("t1_addr0", imem_addr, 32'h0);
    step();
    cmp("t1_wait_req", {31'b0, imem_req}, 32'd0);
    step();
    cmp("t1_if_valid", {31'b0, if_valid}, 32'd1);
    cmp("t1_if_pc", if_pc, 32'h0);
    cmp("t1_if_instr", if_instr, 32'h0050_0093);
    cmp("t1_pc", pc, 32'h4);
    cmp("t1_addr4", imem_addr, 32'h4);
    step(); step();
    cmp("t1_addr8", imem_addr, 32'h8);
    cmp("t1_if_pc4", if_pc, 32'h4);

    // Decode back-pressure.
    id_ready = 1'b0;
    #1 cmp("t2_req_blocked", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("t2_req_held", {31'b0, imem_req}, 32'd0);
      cmp("t2_if_pc_held", if_pc, 32'h4);
      cmp("t2_if_instr_held", if_instr, 32'h0010_0093);
    end
    id_ready = 1'b1;
    #1 cmp("t2_resume", {31'b0, imem_req}, 32'd1);
    cmp("t2_resume_addr", imem_addr, 32'h8);
    step(); step(); step();

    // Flush while waiting; late response must be discarded.
    mem_lat = 3;
    wait_fire();
    step();
    flush = 1'b1; follow = 1'b0; np_fixed = 32'h100;
    step();
    flush = 1'b0;
    #1 cmp("t3_pc", pc, 32'h100);
    cmp("t3_if_valid", {31'b0, if_valid}, 32'd0);
    cmp("t3_drop_req", {31'b0, imem_req}, 32'd0);
    step();
    cmp("t3_rvalid_in_drop_req", {31'b0, imem_req}, 32'd0);
    step();
    cmp("t3_if_valid_after", {31'b0, if_valid}, 32'd0);
    cmp("t3_refetch_req", {31'b0, imem_req}, 32'd1);
    cmp("t3_refetch_addr", imem_addr, 32'h100);
    follow = 1'b1;

    // Flush in the same cycle as rvalid.
    mem_lat = 2;
    wait_fire();
    step(); step();
    flush = 1'b1; follow = 1'b0; np_fixed = 32'h200;
    step();
    flush = 1'b0;
    #1 cmp("t4_pc", pc, 32'h200);
    cmp("t4_if_valid", {31'b0, if_valid}, 32'd0);
    cmp("t4_req", {31'b0, imem_req}, 32'd1);
    cmp("t4_addr", imem_addr, 32'h200);
    follow = 1'b1;

    // Hazard stall across a response.
    step();
    pc_write = 1'b0;
    step();
    cmp("t5_wait_req", {31'b0, imem_req}, 32'd0);
    step();
    cmp("t5_pc_held", pc, 32'h200);
    cmp("t5_if_pc", if_pc, 32'h200);
    cmp("t5_if_instr", if_instr, 32'h2050_0093);
    cmp("t5_if_valid", {31'b0, if_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("t5_no_req", {31'b0, imem_req}, 32'd0);
    end
    pc_write = 1'b1;
    #1 cmp("t5_resume", {31'b0, imem_req}, 32'd1);
    cmp("t5_resume_addr", imem_addr, 32'h200);
    mem_lat = 1;
    step(); step(); step();
    cmp("t5_pc_adv", pc, 32'h204);

    // PC wrap.
    flush = 1'b1; follow = 1'b0; np_fixed = 32'hFFFF_FFFC;
    step();
    flush = 1'b0; follow = 1'b1;
    #1 cmp("t6_pc", pc, 32'hFFFF_FFFC);
    cmp("t6_pc_plus4_wrap", pc_plus4, 32'h0);
    step(); step(); step();
    cmp("t6_pc_wrapped", pc, 32'h0);
    cmp("t6_if_pc", if_pc, 32'hFFFF_FFFC);

    // Reset while a request is outstanding; late rvalid must be ignored.
    mem_lat = 4;
    wait_fire();
    step();
    rst_n = 1'b0;
    m_reset();
    #1 cmp("t7_rst_req", {31'b0, imem_req}, 32'd0);
    cmp("t7_rst_if_valid", {31'b0, if_valid}, 32'd0);
    step();
    rst_n = 1'b1; ack = 1'b0;
    step(); step();
    cmp("t7_late_rvalid_present", {31'b0, rvalid}, 32'd1);
    step();
    cmp("t7_late_ignored", {31'b0, if_valid}, 32'd0);
    cmp("t7_req_fetch", {31'b0, imem_req}, 32'd1);
    cmp("t7_addr", imem_addr, 32'h0);
    ack = 1'b1; mem_lat = 1;
    step(); step(); step();

    // Misaligned redirect target.
    flush = 1'b1; follow = 1'b0; np_fixed = 32'h102;
    step();
    flush = 1'b0; np_fixed = 32'h200;
`ifdef MISALIGN_CHK_EN
    #1 cmp("t8_no_req", {31'b0, imem_req}, 32'd0);
    step();
    cmp("t8_if_valid", {31'b0, if_valid}, 32'd1);
    cmp("t8_if_pc", if_pc, 32'h102);
    cmp("t8_if_instr", if_instr, 32'h0000_0013);
    cmp("t8_misalign", {31'b0, if_misalign}, 32'd1);
    cmp("t8_pc", pc, 32'h200);
    step(); step(); step();
    cmp("t8_misalign_clr", {31'b0, if_misalign}, 32'd0);
`else
    #1 cmp("t8_req", {31'b0, imem_req}, 32'd1);
    cmp("t8_addr_aligned", imem_addr, 32'h100);
    step(); step(); step();
    cmp("t8_if_pc", if_pc, 32'h102);
`endif
    follow = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
